// File: rtl/Pkg_A2_Magnitude.sv
// Types local to the a2_to_magnitude input-conditioning stage.
//   a2m_state_e : controller states, 2-bit encoded
package Pkg_A2_Magnitude;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CONV_MPR = 2'd1,
    S_CONV_MCD = 2'd2,
    S_VALID    = 2'd3
  } a2m_state_e;

endpackage

// File: rtl/Pkg_Global.sv
// Codebase-wide constants shared by the signed sequential multiplier blocks.
//   DW      : operand width
//   DW_2    : product width (2*DW)
//   ONE/ZERO: single-bit constants
//   BIT_ONE : DW-bit value one (used by two's-complement negation)
//   MIN_NEG : most negative DW-bit two's-complement value (1 followed by zeros)
package Pkg_Global;

  localparam int unsigned DW   = 8;
  localparam int unsigned DW_2 = 2 * DW;

  localparam logic ONE  = 1'b1;
  localparam logic ZERO = 1'b0;

  localparam logic [DW-1:0] BIT_ONE = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] MIN_NEG = {1'b1, {(DW-1){1'b0}}};

endpackage

// File: rtl/a2_abs.sv
// Combinational two's-complement absolute value.
//   operand   in  DW : signed operand
//   magnitude out DW : |operand| as unsigned (most negative value maps to 2^(DW-1))
//   is_min    out 1  : operand is the most negative representable value
module a2_abs #(
  parameter int unsigned DW = Pkg_Global::DW
) (
  input  logic [DW-1:0] operand,
  output logic [DW-1:0] magnitude,
  output logic          is_min
);

  localparam logic [DW-1:0] ONE_VAL = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

  always_comb begin
    magnitude = operand;
    if (operand[DW-1]) begin
      magnitude = ~operand + ONE_VAL;
    end
    is_min = (operand == MIN_VAL);
  end

endmodule

// File: rtl/a2_to_magnitude.sv
// Registered input-conditioning stage for the signed sequential multiplier.
// Captures two two's-complement operands on start/ready, converts each to
// magnitude through one shared abs unit (one cycle per operand), then presents
// the result on valid/ack.
//   clk, rst          : clock, synchronous active-high reset
//   start / ready     : operand capture handshake
//   multiplier        : signed operand (DW)
//   multiplicand      : signed operand (DW)
//   valid / ack       : result handshake
//   multiplier_mag    : |multiplier|
//   multiplicand_mag  : |multiplicand|
//   multiplier_msb    : captured sign bit of multiplier
//   multiplicand_msb  : captured sign bit of multiplicand
//   sign              : product sign (XOR of the MSBs)
//   min_flag          : an operand was the most negative value
module a2_to_magnitude
  import Pkg_A2_Magnitude::*;
#(
  parameter int unsigned DW = Pkg_Global::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] multiplier,
  input  logic [DW-1:0] multiplicand,
  output logic          ready,
  output logic          valid,
  input  logic          ack,
  output logic [DW-1:0] multiplier_mag,
  output logic [DW-1:0] multiplicand_mag,
  output logic          multiplier_msb,
  output logic          multiplicand_msb,
  output logic          sign,
  output logic          min_flag
);

  a2m_state_e    state;
  logic [DW-1:0] mpr_reg;
  logic [DW-1:0] mcd_reg;
  logic [DW-1:0] abs_in;
  logic [DW-1:0] abs_mag;
  logic          abs_is_min;

  // Single abs unit shared between the two conversion cycles.
  always_comb begin
    abs_in = mcd_reg;
    if (state == S_CONV_MPR) begin
      abs_in = mpr_reg;
    end
  end

  a2_abs #(
    .DW(DW)
  ) u_abs (
    .operand  (abs_in),
    .magnitude(abs_mag),
    .is_min   (abs_is_min)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      mpr_reg          <= '0;
      mcd_reg          <= '0;
      multiplier_mag   <= '0;
      multiplicand_mag <= '0;
      multiplier_msb   <= 1'b0;
      multiplicand_msb <= 1'b0;
      min_flag         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mpr_reg          <= multiplier;
            mcd_reg          <= multiplicand;
            multiplier_msb   <= multiplier[DW-1];
            multiplicand_msb <= multiplicand[DW-1];
            multiplier_mag   <= '0;
            multiplicand_mag <= '0;
            min_flag         <= 1'b0;
            state            <= S_CONV_MPR;
          end
        end
        S_CONV_MPR: begin
          multiplier_mag <= abs_mag;
          min_flag       <= abs_is_min;
          state          <= S_CONV_MCD;
        end
        S_CONV_MCD: begin
          multiplicand_mag <= abs_mag;
          min_flag         <= min_flag | abs_is_min;
          state            <= S_VALID;
        end
        S_VALID: begin
          if (ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ready is held low while reset is applied so no start is advertised then.
  assign ready = (state == S_IDLE) && !rst;
  assign valid = (state == S_VALID);
  assign sign  = multiplier_msb ^ multiplicand_msb;

endmodule
